// File: rtl/concessao_pkg.sv
// Shared types and constants for the two-interface grant controller.
package concessao_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    GNT0,
    GNT1,
    RELEASE
  } state_t;

  localparam int PERFIL_W     = 3;
  localparam int PERFIL_OUT_W = 2 * PERFIL_W;

  // {a,b,c} carries interface 0's profile, {d,e,f} carries interface 1's
  localparam int PERFIL0_LSB = PERFIL_W;
  localparam int PERFIL1_LSB = 0;

  function automatic logic [PERFIL_OUT_W-1:0] pack_perfil(
    input logic [PERFIL_W-1:0] p0,
    input logic [PERFIL_W-1:0] p1
  );
    logic [PERFIL_OUT_W-1:0] r;
    r = '0;
    r[PERFIL0_LSB +: PERFIL_W] = p0;
    r[PERFIL1_LSB +: PERFIL_W] = p1;
    return r;
  endfunction

endpackage

// File: rtl/concessao_temporizador.sv
// Hold counter for an active grant; flags the last allowed grant cycle.
module concessao_temporizador #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // Saturating count so a long hold can never wrap back into the expiry value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

endmodule

// File: rtl/concessao_interface.sv
// Sequential grant controller: latches profiles for the external priority
// decoder, then issues a held, exclusive grant to one of two interfaces.
module concessao_interface
  import concessao_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [PERFIL_W-1:0]     perfil0,
  input  logic [PERFIL_W-1:0]     perfil1,
  output logic [PERFIL_OUT_W-1:0] perfil_out,
  input  logic                    prio0,
  input  logic                    prio1,
  input  logic                    done,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    busy,
  output logic                    timeout
);

  state_t state;
  logic   last_served;
  logic   tmr_en;
  logic   tmr_clr;
  logic   tmr_expired;
  logic   pick_valid;
  logic   pick0;
  logic   held_req;

  assign tmr_en   = (state == GNT0) || (state == GNT1);
  assign tmr_clr  = !tmr_en;
  assign held_req = (state == GNT0) ? req0 : req1;

  concessao_temporizador #(
    .TIMEOUT(TIMEOUT)
  ) u_temporizador (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  // Ties go to the interface not served last; last_served=1 selects interface 0
  always_comb begin
    pick_valid = req0 || req1;
    pick0      = 1'b0;
    if (req0 && !req1) begin
      pick0 = 1'b1;
    end else if (!req0 && req1) begin
      pick0 = 1'b0;
    end else if (prio0 && !prio1) begin
      pick0 = 1'b1;
    end else if (prio1 && !prio0) begin
      pick0 = 1'b0;
    end else begin
      pick0 = last_served;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      perfil_out  <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      last_served <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            perfil_out <= pack_perfil(perfil0, perfil1);
            state      <= EVAL;
            busy       <= 1'b1;
          end
        end
        EVAL: begin
          if (!pick_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pick0) begin
            state       <= GNT0;
            gnt0        <= 1'b1;
            last_served <= 1'b0;
          end else begin
            state       <= GNT1;
            gnt1        <= 1'b1;
            last_served <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          // A release in the expiry cycle is a normal end, not a timeout
          if (done || !held_req || tmr_expired) begin
            state   <= RELEASE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            timeout <= !done && tmr_expired;
          end
        end
        RELEASE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          timeout <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/concessao_interface.md
# concessao_interface

Sequential grant controller for the two-interface profile arbitration path. It latches each interface's 3-bit profile and drives the six profile lines into the combinational priority decoder. It then samples that decoder's two priority outputs and issues a held, exclusive grant to one interface. Grants end on release, on request withdrawal or on timeout, and ties are resolved round-robin.

## Interface
- TIMEOUT, 16, maximum grant length in cycles; 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0  in  1  request from interface 0.
- req1  in  1  request from interface 1.
- perfil0  in  3  profile of interface 0.
- perfil1  in  3  profile of interface 1.
- perfil_out  out  6  registered profile lines to the priority decoder, {a,b,c,d,e,f}: [5:3]=perfil0, [2:0]=perfil1.
- prio0  in  1  decoder output prioridade0 (interface 0 preferred).
- prio1  in  1  decoder output prioridade1 (interface 1 preferred).
- done  in  1  current grant holder releases.
- gnt0  out  1  grant to interface 0.
- gnt1  out  1  grant to interface 1.
- busy  out  1  FSM not in IDLE.
- timeout  out  1  one-cycle pulse, grant revoked by timeout.

## Operation
- Clocking and reset: one clock (clk); rst_n is asynchronous active-low.
- States: IDLE, EVAL, GNT0, GNT1, RELEASE.
- IDLE:
  - If req0|req1: capture perfil0/perfil1 into perfil_out, go to EVAL.
  - perfil_out is held at all other times.
- EVAL: lasts exactly one cycle, so the decoder settles on the registered profiles. Sample prio0/prio1 and the live requests, then take the first matching rule:
  - Neither req: go to IDLE.
  - Only req0: GNT0. Only req1: GNT1. Priority inputs are ignored in both cases.
  - Both req, prio0&!prio1: GNT0.
  - Both req, prio1&!prio0: GNT1.
  - Both req, with prio0==prio1 (both or neither): grant the interface opposite to last_served.
- On entry to GNTx: set last_served=x and clear the hold counter.
- GNTx:
  - gntx=1, the other grant is 0. Grants are never both high.
  - The counter increments each cycle.
  - Exit to RELEASE on done, or on reqx deasserted.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without done: pulse timeout and go to RELEASE.
  - If done and timeout coincide, done wins and timeout stays 0.
- RELEASE: both grants 0 for exactly one cycle, then IDLE. A waiting requester is therefore re-evaluated against fresh profiles.
- Profile changes during EVAL/GNT/RELEASE are ignored until the next IDLE capture.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- Reset values:
  - State IDLE.
  - perfil_out=6'b0, gnt0=gnt1=0, busy=0, timeout=0.
  - Counter 0; last_served=1, so the first tie goes to interface 0.
- Reset asserted mid-grant drops the grant asynchronously. The same-cycle done is lost.
- All outputs are registered; there is no combinational input-to-output path.
- Latency from request to grant:
  - Request sampled high at edge t0 in IDLE: perfil_out is valid after t0, EVAL runs during t0..t0+1, and gnt rises after edge t0+1.
  - That is 2 cycles from request to grant.
- Latency from release to grant:
  - done sampled at edge t1: gnt falls after t1, RELEASE runs during t1..t1+1, IDLE follows.
  - The next grant is visible after t1+3 at the earliest.
- Maximum grant length is TIMEOUT cycles of gnt high. timeout is high in the cycle after the last one, simultaneous with RELEASE.
- busy=1 in EVAL, GNT0, GNT1 and RELEASE.

## Structure
- Shared package holds:
  - The state enum (IDLE, EVAL, GNT0, GNT1, RELEASE).
  - PERFIL_W=3.
  - The bit-slice constants for the {a..f} mapping of perfil_out.
- The existing priority decoder stays outside this block; it is connected at the next level up.
- The hold counter/timeout sits in one sub-module, concessao_temporizador. Its ports: clk, rst_n, clr, en, expired.

## Test plan
- Reset: drive rst_n=0 mid-GNT0 -> gnt0 drops immediately; after release, state is IDLE and perfil_out=0.
- Single request:
  - Stimulus: req0=1, perfil0=3'b101, req1=0.
  - Required: perfil_out=6'b101000 after 1 edge; gnt0=1 after 2 edges, regardless of prio0/prio1.
  - Then done=1 -> gnt0=0 the next cycle, and 1 RELEASE cycle follows.
- Priority decision: both req, prio0=0, prio1=1 in EVAL -> gnt1=1 and gnt0 never asserts. After done, with req0 still high, gnt0=1 three cycles after done.
- Ties: both req held, prio0=prio1=1, done pulsed each grant -> grants alternate 0,1,0,1 starting with 0 from reset.
- Timeout: TIMEOUT=4, req1 held, done=0 -> gnt1 high for exactly 4 cycles, then timeout=1 for one cycle, then gnt1 re-asserts via a new EVAL.
- Boundary cases:
  - done and timeout in the same cycle -> timeout=0.
  - req0 withdrawn during EVAL with req1=0 -> return to IDLE with no grant.
  - Property: gnt0&gnt1 never both 1.
